unary_frame_accumulator: RTL and testbench

//   Downstream consumer of the node_pow2_adder tree. Accepts one BWIDTH-bit unary
//   (thermometer) word per handshake and adds its ones-count to a running sum.

---
 rtl/unary_pkg.sv | 23 ++
 rtl/unary_popcount.sv | 23 ++
 rtl/unary_frame_accumulator.sv | 117 +++++++++++
 tb/tb_unary_frame_accumulator.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/unary_pkg.sv
// rtl/unary_pkg.sv - shared types and helpers for the unary frame accumulator
package unary_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } ufa_state_t;

    localparam int UW_MAX = 32;

    // A thermometer word has no set bit sitting above a clear bit.
    function automatic logic uw_is_thermo(input logic [UW_MAX-1:0] w, input int bw);
        logic ok;
        ok = 1'b1;
        for (int i = 1; i < UW_MAX; i++) begin
            if (i < bw && w[i] && !w[i-1]) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/unary_popcount.sv
// rtl/unary_popcount.sv - combinational ones-count and thermometer check of one word
module unary_popcount
    import unary_pkg::*;
#(
    parameter int BWIDTH = 4
) (
    input  logic [BWIDTH-1:0]             i_data,
    output logic [$clog2(BWIDTH+1)-1:0]   o_pop,
    output logic                          o_malformed
);

    localparam int PW = $clog2(BWIDTH + 1);

    always_comb begin
        o_pop = '0;
        for (int i = 0; i < BWIDTH; i++) begin
            o_pop = o_pop + PW'(i_data[i]);
        end
    end

    assign o_malformed = !uw_is_thermo(UW_MAX'(i_data), BWIDTH);

endmodule

// File: rtl/unary_frame_accumulator.sv
// rtl/unary_frame_accumulator.sv - sums ones-counts of FRAME_LEN unary words per result
module unary_frame_accumulator
    import unary_pkg::*;
#(
    parameter int BWIDTH    = 4,
    parameter int FRAME_LEN = 16
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      clear,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [BWIDTH-1:0]                         in_data,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [$clog2(BWIDTH*FRAME_LEN+1)-1:0]     out_sum,
    output logic                                      in_err
);

    localparam int ACC_W = $clog2(BWIDTH * FRAME_LEN + 1);
    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam int PW    = $clog2(BWIDTH + 1);

    ufa_state_t          r_state;
    ufa_state_t          w_state_nxt;
    logic [ACC_W-1:0]    r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic [ACC_W-1:0]    r_out_sum;
    logic                r_in_err;
    logic                r_live;
    logic [PW-1:0]       w_pop;
    logic                w_malformed;
    logic                w_accept;
    logic                w_last;
    logic [ACC_W-1:0]    w_acc_sum;

    unary_popcount #(
        .BWIDTH (BWIDTH)
    ) u_popcount (
        .i_data      (in_data),
        .o_pop       (w_pop),
        .o_malformed (w_malformed)
    );

    assign w_last    = (r_cnt == CNT_W'(FRAME_LEN - 1));
    assign w_acc_sum = r_acc + ACC_W'(w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // r_live keeps in_ready low until the first edge after reset release.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ACCUM: begin
                in_ready = r_live;
                if (in_valid && r_live && w_last) begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ACCUM;
                end
            end
            default: w_state_nxt = ACCUM;
        endcase
        if (clear) begin
            w_state_nxt = ACCUM;
        end
    end

    assign w_accept = in_valid && in_ready && !clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live    <= 1'b0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_out_sum <= '0;
            r_in_err  <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (clear) begin
                r_acc    <= '0;
                r_cnt    <= '0;
                r_in_err <= 1'b0;
            end else if (w_accept) begin
                if (w_malformed) begin
                    r_in_err <= 1'b1;
                end
                if (w_last) begin
                    r_out_sum <= w_acc_sum;
                    r_acc     <= '0;
                    r_cnt     <= '0;
                end else begin
                    r_acc <= w_acc_sum;
                    r_cnt <= r_cnt + 1'b1;
                end
            end else if (r_state == HOLD && out_ready) begin
                r_in_err <= 1'b0;
            end
        end
    end

    assign out_sum = r_out_sum;
    assign in_err  = r_in_err;

endmodule

// File: tb/tb_unary_frame_accumulator.sv
// tb/tb_unary_frame_accumulator.sv - scoreboard bench for the unary frame accumulator
module tb_unary_frame_accumulator;

    typedef struct {
        int sum;
        bit err;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       a_clear, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_in_err;
    logic [3:0] a_in_data;
    logic [4:0] a_out_sum;
    logic       b_clear, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_in_err;
    logic [3:0] b_in_data;
    logic [6:0] b_out_sum;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_checks;
    int   n_fail;

    unary_frame_accumulator #(.BWIDTH(4), .FRAME_LEN(4)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (a_clear),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_sum   (a_out_sum),
        .in_err    (a_in_err)
    );

    unary_frame_accumulator #(.BWIDTH(4), .FRAME_LEN(16)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (b_clear),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_sum   (b_out_sum),
        .in_err    (b_in_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n && a_out_valid && a_out_ready) begin
            if (q_a.size() == 0) begin
                chk("a_unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                chk("a_out_sum", int'(a_out_sum), e.sum);
                chk("a_in_err", int'(a_in_err), int'(e.err));
            end
        end
        if (rst_n && b_out_valid && b_out_ready) begin
            if (q_b.size() == 0) begin
                chk("b_unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                chk("b_out_sum", int'(b_out_sum), e.sum);
                chk("b_in_err", int'(b_in_err), int'(e.err));
            end
        end
    end

    task automatic a_send(input logic [3:0] w);
        int t;
        t = 0;
        a_in_valid = 1'b1;
        a_in_data  = w;
        @(negedge clk);
        while (!a_in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!a_in_ready) chk("a_send_timeout", 1, 0);
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        a_in_data  = 4'b0;
    endtask

    task automatic b_send(input logic [3:0] w);
        int t;
        t = 0;
        b_in_valid = 1'b1;
        b_in_data  = w;
        @(negedge clk);
        while (!b_in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!b_in_ready) chk("b_send_timeout", 1, 0);
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        b_in_data  = 4'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain_a", q_a.size(), 0);
        chk("drain_b", q_b.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] f1 [4];
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        a_clear = 1'b0; a_in_valid = 1'b0; a_in_data = 4'b0; a_out_ready = 1'b1;
        b_clear = 1'b0; b_in_valid = 1'b0; b_in_data = 4'b0; b_out_ready = 1'b1;
        f1[0] = 4'b0001; f1[1] = 4'b0011; f1[2] = 4'b0111; f1[3] = 4'b1111;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(a_out_valid), 0);
        chk("rst_in_err", int'(a_in_err), 0);
        chk("rst_out_sum", int'(a_out_sum), 0);
        chk("rst_in_ready_low", int'(a_in_ready), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready_high", int'(a_in_ready), 1);

        // Test 1: back-to-back thermometer words, consumer always ready
        q_a.push_back('{sum: 10, err: 1'b0});
        for (int i = 0; i < 4; i++) a_send(f1[i]);
        chk("t1_latency_valid", int'(a_out_valid), 1);
        chk("t1_in_ready_hold", int'(a_in_ready), 0);
        @(posedge clk);
        #1;
        chk("t1_valid_one_cycle", int'(a_out_valid), 0);
        chk("t1_in_ready_back", int'(a_in_ready), 1);
        drain();

        // Test 2: result held under backpressure
        a_out_ready = 1'b0;
        q_a.push_back('{sum: 10, err: 1'b0});
        for (int i = 0; i < 4; i++) a_send(f1[i]);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t2_hold_valid", int'(a_out_valid), 1);
            chk("t2_hold_sum", int'(a_out_sum), 10);
            chk("t2_hold_in_ready", int'(a_in_ready), 0);
        end
        @(posedge clk);
        #1;
        a_out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("t2_in_ready_after", int'(a_in_ready), 1);
        chk("t2_valid_after", int'(a_out_valid), 0);
        drain();

        // Test 3: malformed first word
        q_a.push_back('{sum: 5, err: 1'b1});
        a_send(4'b0101);
        chk("t3_err_sticky", int'(a_in_err), 1);
        a_send(4'b0001);
        a_send(4'b0001);
        a_send(4'b0001);
        drain();
        chk("t3_err_cleared", int'(a_in_err), 0);

        // Test 4: clear mid-frame drops the beat presented with it
        a_send(4'b1111);
        a_send(4'b1111);
        a_clear    = 1'b1;
        a_in_valid = 1'b1;
        a_in_data  = 4'b1111;
        @(posedge clk);
        #1;
        a_clear    = 1'b0;
        a_in_valid = 1'b0;
        q_a.push_back('{sum: 4, err: 1'b0});
        for (int i = 0; i < 4; i++) a_send(4'b0001);
        drain();

        // Test 5: full-scale frame on the 16-word instance
        q_b.push_back('{sum: 64, err: 1'b0});
        for (int i = 0; i < 16; i++) b_send(4'b1111);
        drain();

        // Test 6: asynchronous reset while a result is held
        a_out_ready = 1'b0;
        a_send(4'b0011);
        a_send(4'b0100);
        a_send(4'b0001);
        a_send(4'b0001);
        chk("t6_hold_valid", int'(a_out_valid), 1);
        chk("t6_hold_err", int'(a_in_err), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", int'(a_out_valid), 0);
        chk("t6_async_err", int'(a_in_err), 0);
        chk("t6_async_sum", int'(a_out_sum), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        a_out_ready = 1'b1;
        q_a.push_back('{sum: 5, err: 1'b0});
        a_send(4'b0001);
        a_send(4'b0001);
        a_send(4'b0011);
        a_send(4'b0001);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
